// File: rtl/led_frame_ctrl.sv
// Frame controller for the 4x8 LED matrix driver: double-buffered row store
// published on scan-frame boundaries, frame-paced brightness fade and blink.
module led_frame_ctrl #(
    parameter int         FRAME_CYCLES = 8192,
    parameter int         FADE_FRAMES  = 16,
    parameter int         BLINK_FRAMES = 64,
    parameter logic [2:0] PWM_RESET    = 3'd7
) (
    input  logic       clk12MHz,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [1:0] wr_row,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    input  logic       commit_req,
    output logic       commit_ack,
    input  logic [2:0] pwm_target,
    input  logic       blink_en,
    output logic       frame_tick,
    output logic [7:0] leds1,
    output logic [7:0] leds2,
    output logic [7:0] leds3,
    output logic [7:0] leds4,
    output logic [2:0] leds_pwm
);

    localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int FW = (FADE_FRAMES  > 1) ? $clog2(FADE_FRAMES)  : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_CYCLES - 1);
    localparam logic [FW-1:0] FADE_LAST  = FW'(FADE_FRAMES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_ACK     = 2'd2
    } commit_state_t;

    commit_state_t  state, state_nxt;
    logic [CW-1:0]  frame_cnt, frame_cnt_nxt;
    logic [FW-1:0]  fade_cnt;
    logic [BW-1:0]  blink_cnt;
    logic           blink_on;
    logic           publish;
    logic           wr_accept;
    logic [7:0]     back_buf  [4];
    logic [7:0]     front_buf [4];

    // frame_tick is registered one cycle early so it is high while the count is last
    assign frame_cnt_nxt = (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + CW'(1);

    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt  <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_cnt  <= frame_cnt_nxt;
            frame_tick <= (frame_cnt_nxt == FRAME_LAST);
        end
    end

    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (commit_req) state_nxt = ST_PENDING;
            ST_PENDING: if (frame_tick) state_nxt = ST_ACK;
            ST_ACK:     state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        publish   = (state == ST_PENDING) && frame_tick;
        wr_accept = wr_en && wr_ready;
    end

    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            wr_ready   <= 1'b1;
            commit_ack <= 1'b0;
        end else begin
            wr_ready   <= (state_nxt == ST_IDLE);
            commit_ack <= publish;
        end
    end

    // back keeps its contents after a publish so the host can edit incrementally
    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                back_buf[i]  <= '0;
                front_buf[i] <= '0;
            end
        end else begin
            if (wr_accept) back_buf[wr_row] <= wr_data;
            if (publish) begin
                for (int i = 0; i < 4; i++) front_buf[i] <= back_buf[i];
            end
        end
    end

    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            fade_cnt <= '0;
            leds_pwm <= PWM_RESET;
        end else if (frame_tick) begin
            if (fade_cnt == FADE_LAST) begin
                fade_cnt <= '0;
                if (leds_pwm < pwm_target)      leds_pwm <= leds_pwm + 3'd1;
                else if (leds_pwm > pwm_target) leds_pwm <= leds_pwm - 3'd1;
            end else begin
                fade_cnt <= fade_cnt + FW'(1);
            end
        end
    end

    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (!blink_en) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_tick) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    assign leds1 = blink_on ? front_buf[0] : 8'h00;
    assign leds2 = blink_on ? front_buf[1] : 8'h00;
    assign leds3 = blink_on ? front_buf[2] : 8'h00;
    assign leds4 = blink_on ? front_buf[3] : 8'h00;

endmodule

// File: tb/tb_led_frame_ctrl.sv
// Bench for led_frame_ctrl: directed scenarios plus random traffic, all
// compared against a frame-arithmetic reference model.
module tb_led_frame_ctrl;

    localparam int FC = 16;
    localparam int FF = 2;
    localparam int BF = 3;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_row;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       commit_req;
    logic       commit_ack;
    logic [2:0] pwm_target;
    logic       blink_en;
    logic       frame_tick;
    logic [7:0] leds1, leds2, leds3, leds4;
    logic [2:0] leds_pwm;

    int checks   = 0;
    int failures = 0;

    led_frame_ctrl #(
        .FRAME_CYCLES(FC),
        .FADE_FRAMES (FF),
        .BLINK_FRAMES(BF),
        .PWM_RESET   (3'd7)
    ) dut (
        .clk12MHz  (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_row    (wr_row),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .commit_req(commit_req),
        .commit_ack(commit_ack),
        .pwm_target(pwm_target),
        .blink_en  (blink_en),
        .frame_tick(frame_tick),
        .leds1     (leds1),
        .leds2     (leds2),
        .leds3     (leds3),
        .leds4     (leds4),
        .leds_pwm  (leds_pwm)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] dut_rows;
    logic [37:0] dut_vec;
    assign dut_rows = {leds1, leds2, leds3, leds4};
    assign dut_vec  = {leds1, leds2, leds3, leds4, leds_pwm, wr_ready, commit_ack, frame_tick};

    // ---------------- reference model ----------------
    // Time is counted in cycles since reset release; a frame ends whenever the
    // cycle index is one short of a multiple of FC.
    logic [7:0] m_back  [4];
    logic [7:0] m_front [4];
    int m_cyc, m_ticks, m_bt, m_pwm;
    bit m_pend, m_ack, m_tk, m_ack_nx;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 4; i++) begin
                    m_back[i]  = 8'h00;
                    m_front[i] = 8'h00;
                end
                m_cyc = 0; m_ticks = 0; m_bt = 0; m_pwm = 7;
                m_pend = 0; m_ack = 0;
            end else begin
                m_tk = (m_cyc % FC) == FC - 1;
                if (wr_en && !m_pend && !m_ack) m_back[wr_row] = wr_data;
                m_ack_nx = m_pend && m_tk;
                if (m_pend && m_tk) begin
                    for (int i = 0; i < 4; i++) m_front[i] = m_back[i];
                    m_pend = 0;
                end else if (!m_pend && !m_ack && commit_req) begin
                    m_pend = 1;
                end
                m_ack = m_ack_nx;
                if (m_tk) begin
                    m_ticks++;
                    if (m_ticks % FF == 0) begin
                        if (m_pwm < int'(pwm_target))      m_pwm++;
                        else if (m_pwm > int'(pwm_target)) m_pwm--;
                    end
                end
                if (!blink_en) m_bt = 0;
                else if (m_tk) m_bt++;
                m_cyc++;
            end
        end
    end

    function automatic logic [37:0] model_vec();
        logic [7:0] r [4];
        bit on;
        on = ((m_bt / BF) % 2) == 0;
        for (int i = 0; i < 4; i++) r[i] = on ? m_front[i] : 8'h00;
        return {r[0], r[1], r[2], r[3], 3'(m_pwm), !(m_pend || m_ack), m_ack,
                ((m_cyc % FC) == FC - 1)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        wr_en = 0; wr_row = 0; wr_data = 0; commit_req = 0;
        pwm_target = 3'd7; blink_en = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #7;
        checks++;
        if ({dut_rows, leds_pwm, wr_ready, commit_ack, frame_tick} !== {32'h0, 3'd7, 3'b100}) begin
            failures++;
            $display("FAIL reset_values: got %h expected %h",
                     {dut_rows, leds_pwm, wr_ready, commit_ack, frame_tick}, {32'h0, 3'd7, 3'b100});
        end
        apply_reset();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            checks++;
            if (frame_tick !== (k == 15 || k == 31)) begin
                failures++;
                $display("FAIL reset_tick k=%0d: got %b expected %b", k, frame_tick, (k == 15 || k == 31));
            end
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL reset_idle k=%0d: got %h expected %h", k, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_commit();
        logic [7:0] rows [4];
        rows[0] = 8'hA5; rows[1] = 8'h3C; rows[2] = 8'hFF; rows[3] = 8'h01;
        apply_reset();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL commit_model k=%0d: got %h expected %h", k, dut_vec, model_vec());
            end
            if (k >= 6 && k <= 16) begin
                checks++;
                if (wr_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL commit_ready_low k=%0d: got %b expected 0", k, wr_ready);
                end
            end
            if (k <= 15) begin
                checks++;
                if (dut_rows !== 32'h0) begin
                    failures++;
                    $display("FAIL commit_early k=%0d: got %h expected 0", k, dut_rows);
                end
            end
            if (k >= 16) begin
                checks++;
                if (dut_rows !== 32'hA53CFF01) begin
                    failures++;
                    $display("FAIL commit_rows k=%0d: got %h expected a53cff01", k, dut_rows);
                end
            end
            checks++;
            if (commit_ack !== (k == 16)) begin
                failures++;
                $display("FAIL commit_ack k=%0d: got %b expected %b", k, commit_ack, (k == 16));
            end
            if (k >= 17) begin
                checks++;
                if (wr_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL commit_ready_back k=%0d: got %b expected 1", k, wr_ready);
                end
            end
            wr_en      = (k < 4);
            wr_row     = 2'(k);
            wr_data    = (k < 4) ? rows[k] : 8'h00;
            commit_req = (k == 5);
        end
    endtask

    // Runs straight after test_commit: absolute cycles 20..35.
    task automatic test_write_dropped();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL drop_model k=%0d: got %h expected %h", k, dut_vec, model_vec());
            end
            if (k == 3) begin
                checks++;
                if (wr_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL drop_pending: got wr_ready=%b expected 0", wr_ready);
                end
            end
            if (k >= 12) begin
                checks++;
                if (dut_rows !== 32'hA53CFF01) begin
                    failures++;
                    $display("FAIL drop_rows k=%0d: got %h expected a53cff01", k, dut_rows);
                end
            end
            commit_req = (k == 0);
            wr_en      = (k == 3);
            wr_row     = 2'd1;
            wr_data    = 8'hEE;
        end
        wr_en = 0;
    endtask

    task automatic test_commit_on_tick();
        apply_reset();
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL ontick_model k=%0d: got %h expected %h", k, dut_vec, model_vec());
            end
            if (k == 16 || k == 31) begin
                checks++;
                if ({leds3, wr_ready} !== {8'h00, 1'b0}) begin
                    failures++;
                    $display("FAIL ontick_nopublish k=%0d: got %h expected 000", k, {leds3, wr_ready});
                end
            end
            if (k == 32) begin
                checks++;
                if ({leds3, commit_ack} !== {8'h55, 1'b1}) begin
                    failures++;
                    $display("FAIL ontick_publish: got %h expected ab", {leds3, commit_ack});
                end
            end
            wr_en      = (k == 15);
            wr_row     = 2'd2;
            wr_data    = 8'h55;
            commit_req = (k == 15);
        end
    endtask

    task automatic test_fade();
        apply_reset();
        pwm_target = 3'd2;
        for (int k = 0; k < 201; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL fade_model k=%0d: got %h expected %h", k, dut_vec, model_vec());
            end
            if (k == 31 || k == 32 || k == 64 || k == 96 || k == 200) begin
                checks++;
                if (leds_pwm !== ((k == 31) ? 3'd7 : (k == 32) ? 3'd6 : (k == 64) ? 3'd5 : 3'd4)) begin
                    failures++;
                    $display("FAIL fade_redirect k=%0d: got %0d", k, leds_pwm);
                end
            end
            if (k == 64) pwm_target = 3'd4;
        end
        apply_reset();
        pwm_target = 3'd2;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL fade_down_model k=%0d: got %h expected %h", k, dut_vec, model_vec());
            end
        end
        checks++;
        if (leds_pwm !== 3'd2) begin
            failures++;
            $display("FAIL fade_hold: got %0d expected 2", leds_pwm);
        end
    endtask

    task automatic test_blink();
        apply_reset();
        pwm_target = 3'd0;
        for (int k = 0; k < 130; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL blink_model k=%0d: got %h expected %h", k, dut_vec, model_vec());
            end
            if (k == 16 || k == 63 || k == 64 || k == 111 || k == 112) begin
                checks++;
                if (dut_rows !== ((k == 64 || k == 111) ? 32'h0 : 32'hFFFFFFFF)) begin
                    failures++;
                    $display("FAIL blink_phase k=%0d: got %h", k, dut_rows);
                end
            end
            wr_en      = (k < 4);
            wr_row     = 2'(k);
            wr_data    = 8'hFF;
            commit_req = (k == 4);
            blink_en   = (k >= 16 && k < 120);
        end
    endtask

    // Runs after test_blink with FF rows published and brightness faded down.
    task automatic test_reset_mid_commit();
        @(negedge clk);
        commit_req = 1;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_pending: got wr_ready=%b expected 0", wr_ready);
        end
        #3 rst_n = 0;
        #1;
        checks++;
        if ({dut_rows, leds_pwm, wr_ready, commit_ack, frame_tick} !== {32'h0, 3'd7, 3'b100}) begin
            failures++;
            $display("FAIL midrst_async: got %h expected %h",
                     {dut_rows, leds_pwm, wr_ready, commit_ack, frame_tick}, {32'h0, 3'd7, 3'b100});
        end
        idle_inputs();
        @(posedge clk);
        #1 rst_n = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL midrst_model k=%0d: got %h expected %h", k, dut_vec, model_vec());
            end
            if (k == 16) begin
                checks++;
                if ({dut_rows, commit_ack} !== {32'h0, 1'b1}) begin
                    failures++;
                    $display("FAIL midrst_cleared: got %h expected 000000001", {dut_rows, commit_ack});
                end
            end
            commit_req = (k == 0);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        commit_req = 1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL b2b_model k=%0d: got %h expected %h", k, dut_vec, model_vec());
            end
            wr_en   = 1;
            wr_row  = 2'($urandom_range(0, 3));
            wr_data = 8'($urandom);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL random_model k=%0d: got %h expected %h", k, dut_vec, model_vec());
            end
            wr_en      = 1'($urandom_range(0, 1));
            wr_row     = 2'($urandom_range(0, 3));
            wr_data    = 8'($urandom);
            commit_req = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 39) == 0)  pwm_target = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) blink_en = ~blink_en;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 0;
        idle_inputs();
        test_reset();
        test_commit();
        test_write_dropped();
        test_commit_on_tick();
        test_fade();
        test_blink();
        test_reset_mid_commit();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
